uart_tx_arbiter: RTL and testbench
==================================

# uart_tx_arbiter

Round-robin scheduler that shares one UART transmitter between several byte-stream requesters (CPU APB bridge, debug monitor, DMA). It sits between the requesters and the UART core's `send`/`DATA_TX` inputs. It sequences one byte at a time: it accepts a byte, pulses `send`, then waits for the UART's done flag. It holds the grant across multi-byte packets so that frames from different requesters never interleave.

## Interface
- `NUM_REQ`, 2: number of requesters, valid range 2..8.
- `TIMEOUT_CYCLES`, 2_000_000: the arbiter aborts a byte if no done edge arrives within this many cycles after `send`. 0 disables the timeout.
- `PCLK  in  1`: the single clock.
- `PRESETn  in  1`: asynchronous, active-low reset.
- `req_valid  in  NUM_REQ`: per-requester byte available.
- `req_data  in  8*NUM_REQ`: byte of requester i at [8i+7:8i].
- `req_last  in  NUM_REQ`: the offered byte ends its packet.
- `req_ready  out  NUM_REQ`: one-hot accept strobe.
- `grant  out  NUM_REQ`: one-hot current owner, 0 when idle and unlocked.
- `tx_done_flag  in  1`: done indication from the UART core; only its rising edge is used.
- `tx_active_flag  in  1`: UART busy; the arbiter does not accept a byte while it is high.
- `send  out  1`: one-cycle start pulse to the UART.
- `DATA_TX  out  8`: byte to transmit, held stable from `send` until completion.
- `busy  out  1`: high in any state other than IDLE, or while a packet lock is held.
- `timeout_err  out  1`: one-cycle pulse when a byte is aborted.

## Operation
- FSM states: IDLE, SEND, WAIT_DONE.
- **IDLE, unlocked:** if any `req_valid` is set and `tx_active_flag`=0, the round-robin arbiter picks winner g.
  - `req_ready[g]`=1 combinationally in the same cycle; the handshake completes in that cycle.
  - `DATA_TX` <= `req_data[g]`.
  - lock <= !`req_last[g]`.
  - `grant` <= g.
  - Next state is SEND.
- **IDLE, locked:** only the owner is considered; other requesters wait even when valid. If the owner has no valid byte, the FSM stays in IDLE with the lock held. There is no lock timeout.
- **SEND:** `send`=1 for exactly this cycle; the timeout counter loads 0; next state is WAIT_DONE.
- **WAIT_DONE:**
  - A rising edge of `tx_done_flag` (`tx_done_flag & ~done_q`) moves the FSM to IDLE.
  - If the counter reaches `TIMEOUT_CYCLES` first, the FSM pulses `timeout_err`, clears the lock and `grant`, and moves to IDLE.
- **Round-robin pointer:** after a packet completes (last byte done, or timeout), priority starts at owner+1 mod `NUM_REQ`. The pointer does not move between bytes of a locked packet.
- **`grant`:** cleared on return to IDLE when unlocked; held while locked.
- **Done edges:** an edge seen in IDLE or SEND is ignored. `done_q` updates every cycle.
- **Reset values:** `send`=0, `DATA_TX`=8'h00, `req_ready`=0, `grant`=0, `busy`=0, `timeout_err`=0, state IDLE, lock clear, pointer at requester 0.
- **Reset mid-byte:** everything clears asynchronously; the byte in flight is dropped with no error pulse.

## Timing
- Handshake in cycle N gives `send` in cycle N+1. WAIT_DONE starts at N+2.
- A done edge sampled in cycle M gives IDLE at M+1. The next accept is possible at M+1, so minimum overhead between bytes is 2 cycles plus the UART frame time.
- `req_ready` is never high in two consecutive cycles.
- Multiple requesters valid in the same cycle are resolved by the pointer only; there is no fixed priority.
- A requester that drops `req_valid` before `req_ready` loses nothing; its byte is not taken.
- Timeout counter width is $clog2(TIMEOUT_CYCLES+1). The counter saturates and does not wrap.

## Structure
- Package `uart_arb_pkg` holds:
  - the state enum `arb_state_e` (IDLE, SEND, WAIT_DONE);
  - `MAX_REQ` = 8;
  - the default `TIMEOUT_CYCLES`.
- Sub-module `rr_arbiter`:
  - parameter `N`;
  - inputs `req`, `ptr`;
  - output one-hot `gnt`, purely combinational.
- The FSM, lock, pointer, edge detect and timeout counter live in `uart_tx_arbiter`.

## Test plan
- **Single byte:** req0 sends 8'hA5 with last=1 -> `req_ready[0]` for 1 cycle, `send` the next cycle with `DATA_TX`=8'hA5; done edge 20 cycles later -> IDLE, `grant`=0.
- **Round-robin:** both requesters valid continuously, single-byte packets -> grants go 0,1,0,1; each DATA_TX matches its source.
- **Packet lock:** req1 sends 3 bytes (last only on the third) while req0 is valid -> all 3 of req1's bytes go first, then req0 is granted.
- **Timeout:** `TIMEOUT_CYCLES`=50 and no done edge -> `timeout_err` pulses 50 cycles after WAIT_DONE entry; lock cleared; the other requester is granted next.
- **Stale done and busy UART:** `tx_done_flag` held high from the previous byte gives no early completion. `tx_active_flag`=1 in IDLE -> no `req_ready` until it falls.
- **Reset mid-operation:** PRESETn low in WAIT_DONE -> all outputs go to 0 asynchronously; after release, req0 has priority.

Source files
------------

// File: rtl/uart_arb_pkg.sv
// Shared types and constants for the UART transmit arbiter.
package uart_arb_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SEND,
        WAIT_DONE
    } arb_state_e;

    localparam int MAX_REQ            = 8;
    localparam int DEF_TIMEOUT_CYCLES = 2_000_000;

    function automatic int unsigned oh_to_idx(input logic [MAX_REQ-1:0] oh);
        int unsigned idx;
        idx = 0;
        for (int i = 0; i < MAX_REQ; i++) begin
            if (oh[i]) idx = unsigned'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/uart_tx_arbiter_if.sv
// Requester and UART-core signals of the transmit arbiter, grouped in one bundle.
interface uart_tx_arbiter_if #(
    parameter int NUM_REQ = 2
);
    logic [NUM_REQ-1:0]   req_valid;
    logic [8*NUM_REQ-1:0] req_data;
    logic [NUM_REQ-1:0]   req_last;
    logic [NUM_REQ-1:0]   req_ready;
    logic [NUM_REQ-1:0]   grant;
    logic                 tx_done_flag;
    logic                 tx_active_flag;
    logic                 send;
    logic [7:0]           DATA_TX;
    logic                 busy;
    logic                 timeout_err;

    modport master (
        output req_valid, req_data, req_last, tx_done_flag, tx_active_flag,
        input  req_ready, grant, send, DATA_TX, busy, timeout_err
    );

    modport slave (
        input  req_valid, req_data, req_last, tx_done_flag, tx_active_flag,
        output req_ready, grant, send, DATA_TX, busy, timeout_err
    );
endinterface

// File: rtl/uart_tx_arbiter_rr_arbiter.sv
// Combinational round-robin picker: first set request at or after ptr wins.
module rr_arbiter #(
    parameter int N = 2
) (
    input  logic [N-1:0]         req,
    input  logic [$clog2(N)-1:0] ptr,
    output logic [N-1:0]         gnt
);
    localparam int PTR_W = $clog2(N);

    logic             w_found;
    logic [PTR_W-1:0] w_idx;

    always_comb begin
        gnt     = '0;
        w_found = 1'b0;
        w_idx   = '0;
        for (int i = 0; i < N; i++) begin
            w_idx = PTR_W'((int'(ptr) + i) % N);
            if (!w_found && req[w_idx]) begin
                gnt[w_idx] = 1'b1;
                w_found    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Shares one UART transmitter among NUM_REQ byte streams, one byte at a time,
// holding ownership across multi-byte packets.
module uart_tx_arbiter
    import uart_arb_pkg::*;
#(
    parameter int NUM_REQ        = 2,
    parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
    input  logic             PCLK,
    input  logic             PRESETn,
    uart_tx_arbiter_if.slave bus
);
    localparam int PTR_W = $clog2(NUM_REQ);
    localparam int CNT_W = (TIMEOUT_CYCLES == 0) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
    localparam bit TO_EN = (TIMEOUT_CYCLES != 0);
    // Compare one early so the error pulse lands exactly TIMEOUT_CYCLES after WAIT_DONE entry.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_SAT  = {CNT_W{1'b1}};

    arb_state_e         r_state;
    logic               r_lock;
    logic [NUM_REQ-1:0] r_grant;
    logic [PTR_W-1:0]   r_ptr;
    logic [PTR_W-1:0]   r_owner;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_done_q;
    logic               r_send;
    logic               r_busy;
    logic               r_timeout_err;
    logic [7:0]         r_data;

    logic [NUM_REQ-1:0] w_req;
    logic [NUM_REQ-1:0] w_gnt;
    logic               w_accept;
    logic               w_done_rise;
    logic               w_timeout;
    logic [PTR_W-1:0]   w_gidx;
    logic [PTR_W-1:0]   w_ptr_next;

    // While a packet lock is held only the owner may be picked.
    assign w_req = r_lock ? (bus.req_valid & r_grant) : bus.req_valid;

    rr_arbiter #(.N(NUM_REQ)) u_rr (
        .req (w_req),
        .ptr (r_ptr),
        .gnt (w_gnt)
    );

    assign w_accept    = (r_state == IDLE) && !bus.tx_active_flag && (|w_req);
    assign w_gidx      = PTR_W'(oh_to_idx(MAX_REQ'(w_gnt)));
    assign w_done_rise = bus.tx_done_flag & ~r_done_q;
    assign w_timeout   = TO_EN && (r_cnt == CNT_LAST);
    assign w_ptr_next  = (r_owner == PTR_W'(NUM_REQ - 1)) ? '0 : r_owner + 1'b1;

    assign bus.req_ready   = w_accept ? w_gnt : '0;
    assign bus.send        = r_send;
    assign bus.DATA_TX     = r_data;
    assign bus.grant       = r_grant;
    assign bus.busy        = r_busy;
    assign bus.timeout_err = r_timeout_err;

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            r_state       <= IDLE;
            r_lock        <= 1'b0;
            r_grant       <= '0;
            r_ptr         <= '0;
            r_owner       <= '0;
            r_cnt         <= '0;
            r_done_q      <= 1'b0;
            r_send        <= 1'b0;
            r_busy        <= 1'b0;
            r_timeout_err <= 1'b0;
            r_data        <= 8'h00;
        end else begin
            r_done_q      <= bus.tx_done_flag;
            r_send        <= 1'b0;
            r_timeout_err <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_data  <= bus.req_data[8*w_gidx +: 8];
                        r_lock  <= ~|(bus.req_last & w_gnt);
                        r_grant <= w_gnt;
                        r_owner <= w_gidx;
                        r_send  <= 1'b1;
                        r_busy  <= 1'b1;
                        r_state <= SEND;
                    end
                end
                SEND: begin
                    r_cnt   <= '0;
                    r_state <= WAIT_DONE;
                end
                WAIT_DONE: begin
                    if (w_done_rise) begin
                        r_state <= IDLE;
                        r_busy  <= r_lock;
                        if (!r_lock) begin
                            r_grant <= '0;
                            r_ptr   <= w_ptr_next;
                        end
                    end else if (w_timeout) begin
                        r_state       <= IDLE;
                        r_timeout_err <= 1'b1;
                        r_lock        <= 1'b0;
                        r_grant       <= '0;
                        r_busy        <= 1'b0;
                        r_ptr         <= w_ptr_next;
                    end else if (r_cnt != CNT_SAT) begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter with two requesters and a 50-cycle timeout.
module tb_uart_tx_arbiter;
    logic clk = 1'b0;
    logic rst_n;
    int   checks = 0;
    int   errors = 0;

    uart_tx_arbiter_if #(.NUM_REQ(2)) bus ();

    uart_tx_arbiter #(.NUM_REQ(2), .TIMEOUT_CYCLES(50)) dut (
        .PCLK    (clk),
        .PRESETn (rst_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic [1:0] v, input logic [7:0] d0, input logic [7:0] d1,
                         input logic [1:0] l);
        bus.req_valid = v;
        bus.req_data  = {d1, d0};
        bus.req_last  = l;
    endtask

    // Produce a fresh rising edge on the done flag; returns in the following IDLE cycle.
    task automatic finish_byte();
        bus.tx_done_flag = 1'b0;
        tick();
        bus.tx_done_flag = 1'b1;
        tick();
    endtask

    task automatic send_byte(input string tag, input logic [1:0] v, input logic [7:0] d0,
                             input logic [7:0] d1, input logic [1:0] l,
                             input logic [1:0] exp_g, input logic [7:0] exp_d);
        drive(v, d0, d1, l);
        #1;
        chk({tag, " ready"}, bus.req_ready, exp_g);
        tick();
        chk({tag, " send"}, bus.send, 1);
        chk({tag, " data"}, bus.DATA_TX, exp_d);
        chk({tag, " grant"}, bus.grant, exp_g);
        chk({tag, " ready gap"}, bus.req_ready, 0);
        tick();
        chk({tag, " send one cycle"}, bus.send, 0);
        finish_byte();
    endtask

    initial begin
        rst_n              = 1'b0;
        bus.tx_done_flag   = 1'b0;
        bus.tx_active_flag = 1'b0;
        drive(2'b00, 8'h00, 8'h00, 2'b00);
        repeat (3) tick();
        chk("rst send", bus.send, 0);
        chk("rst data", bus.DATA_TX, 0);
        chk("rst ready", bus.req_ready, 0);
        chk("rst grant", bus.grant, 0);
        chk("rst busy", bus.busy, 0);
        chk("rst timeout", bus.timeout_err, 0);
        rst_n = 1'b1;
        tick();

        // Single byte, done edge about 20 cycles after send
        drive(2'b01, 8'hA5, 8'h00, 2'b01);
        #1;
        chk("single ready", bus.req_ready, 2'b01);
        tick();
        drive(2'b00, 8'hA5, 8'h00, 2'b01);
        chk("single send", bus.send, 1);
        chk("single data", bus.DATA_TX, 8'hA5);
        chk("single grant", bus.grant, 2'b01);
        chk("single ready gap", bus.req_ready, 0);
        tick();
        chk("single send low", bus.send, 0);
        repeat (18) tick();
        chk("single busy wait", bus.busy, 1);
        chk("single data held", bus.DATA_TX, 8'hA5);
        bus.tx_done_flag = 1'b1;
        tick();
        chk("single grant idle", bus.grant, 0);
        chk("single busy idle", bus.busy, 0);

        // Fresh reset so the pointer starts at requester 0
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();

        send_byte("rr0", 2'b11, 8'h11, 8'h22, 2'b11, 2'b01, 8'h11);
        send_byte("rr1", 2'b11, 8'h11, 8'h22, 2'b11, 2'b10, 8'h22);
        send_byte("rr2", 2'b11, 8'h11, 8'h22, 2'b11, 2'b01, 8'h11);
        send_byte("rr3", 2'b11, 8'h11, 8'h22, 2'b11, 2'b10, 8'h22);

        // Packet lock: req1 owns the UART for three bytes while req0 waits
        send_byte("lock b1", 2'b10, 8'hC0, 8'hB1, 2'b00, 2'b10, 8'hB1);
        drive(2'b01, 8'hC0, 8'hB1, 2'b01);
        #1;
        chk("lock hold ready", bus.req_ready, 0);
        tick();
        chk("lock hold ready2", bus.req_ready, 0);
        chk("lock hold grant", bus.grant, 2'b10);
        chk("lock hold busy", bus.busy, 1);
        send_byte("lock b2", 2'b11, 8'hC0, 8'hB2, 2'b01, 2'b10, 8'hB2);
        send_byte("lock b3", 2'b11, 8'hC0, 8'hB3, 2'b11, 2'b10, 8'hB3);
        chk("lock released grant", bus.grant, 0);
        chk("lock released busy", bus.busy, 0);
        send_byte("lock then r0", 2'b11, 8'hC0, 8'hB3, 2'b11, 2'b01, 8'hC0);

        // Timeout: req1 starts a packet, no done edge arrives
        drive(2'b11, 8'hD0, 8'hD1, 2'b00);
        #1;
        chk("to ready", bus.req_ready, 2'b10);
        tick();
        chk("to send", bus.send, 1);
        chk("to data", bus.DATA_TX, 8'hD1);
        tick();
        repeat (49) tick();
        chk("to early", bus.timeout_err, 0);
        chk("to busy before", bus.busy, 1);
        tick();
        chk("to pulse", bus.timeout_err, 1);
        chk("to grant cleared", bus.grant, 0);
        chk("to busy cleared", bus.busy, 0);
        drive(2'b11, 8'hD0, 8'hD1, 2'b01);
        #1;
        chk("to next ready", bus.req_ready, 2'b01);
        tick();
        chk("to pulse single", bus.timeout_err, 0);
        chk("to next send", bus.send, 1);
        chk("to next data", bus.DATA_TX, 8'hD0);
        chk("to next grant", bus.grant, 2'b01);
        tick();
        finish_byte();
        chk("to next idle grant", bus.grant, 0);

        // Busy UART blocks acceptance; stale high done gives no early finish
        bus.tx_active_flag = 1'b1;
        drive(2'b01, 8'hE5, 8'h00, 2'b01);
        #1;
        chk("active ready", bus.req_ready, 0);
        tick();
        chk("active ready2", bus.req_ready, 0);
        chk("active busy", bus.busy, 0);
        bus.tx_active_flag = 1'b0;
        #1;
        chk("active released ready", bus.req_ready, 2'b01);
        tick();
        chk("active send", bus.send, 1);
        chk("active data", bus.DATA_TX, 8'hE5);
        tick();
        repeat (3) tick();
        chk("stale busy", bus.busy, 1);
        chk("stale grant", bus.grant, 2'b01);
        finish_byte();
        chk("stale done busy", bus.busy, 0);

        // Reset while waiting for done
        drive(2'b10, 8'h00, 8'hF1, 2'b10);
        #1;
        chk("mid ready", bus.req_ready, 2'b10);
        tick();
        tick();
        chk("mid busy", bus.busy, 1);
        rst_n = 1'b0;
        drive(2'b00, 8'h00, 8'h00, 2'b00);
        #1;
        chk("mid rst send", bus.send, 0);
        chk("mid rst data", bus.DATA_TX, 0);
        chk("mid rst ready", bus.req_ready, 0);
        chk("mid rst grant", bus.grant, 0);
        chk("mid rst busy", bus.busy, 0);
        chk("mid rst timeout", bus.timeout_err, 0);
        tick();
        rst_n = 1'b1;
        tick();
        drive(2'b11, 8'h01, 8'h02, 2'b11);
        #1;
        chk("post rst ready", bus.req_ready, 2'b01);
        tick();
        chk("post rst data", bus.DATA_TX, 8'h01);
        chk("post rst grant", bus.grant, 2'b01);
        tick();
        finish_byte();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
